alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Accumulator ALU command sequencer: one-cycle logic/add ops, WIDTH-cycle shift-add multiply,
// and an optional WIDTH-cycle restoring divider built only when ALU_SEQ_DIV_EN is defined.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] rem,
  output logic             carry,
  output logic             err,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_MULT  = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DIV  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     sum_ext;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic [WIDTH:0]     rshift;
  logic [WIDTH-1:0]   rdiff;
  logic [WIDTH-1:0]   rmd_next;
  logic [WIDTH-1:0]   quo_next;
  logic               q_bit;
`endif

  // Next-state and datapath computation for every register
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    carry_d   = carry_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_next = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    sum_ext   = {1'b0, acc_q} + {1'b0, opd_q};
`ifdef ALU_SEQ_DIV_EN
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    rshift    = {rmd_q, quo_q[WIDTH-1]};
    rdiff     = rshift[WIDTH-1:0] - opd_q;
    q_bit     = (rshift >= {1'b0, opd_q});
    rmd_next  = q_bit ? rdiff : rshift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d  = cmd_opcode;
          opd_d = cmd_operand;
          cnt_d = {CW{1'b0}};
          if (cmd_opcode == OP_MULT) begin
            state_d  = MUL;
            prod_d   = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = cmd_operand;
`ifdef ALU_SEQ_DIV_EN
          end else if ((cmd_opcode == OP_DIV) && (cmd_operand != {WIDTH{1'b0}})) begin
            state_d = DIV;
            quo_d   = acc_q;
            rmd_d   = {WIDTH{1'b0}};
`endif
          end else begin
            state_d = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end

      EXEC: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b0;
        case (op_q)
          OP_NOOP: begin
            acc_d = acc_q;
          end
          OP_RESET: begin
            acc_d   = {WIDTH{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            carry_d = 1'b0;
          end
          OP_ADD: begin
            acc_d   = sum_ext[WIDTH-1:0];
            carry_d = sum_ext[WIDTH];
          end
          OP_SUB: begin
            acc_d   = acc_q - opd_q;
            carry_d = (opd_q > acc_q);
          end
          OP_AND: begin
            acc_d   = acc_q & opd_q;
            carry_d = 1'b0;
          end
          OP_OR: begin
            acc_d   = acc_q | opd_q;
            carry_d = 1'b0;
          end
          OP_NOT: begin
            acc_d   = ~acc_q;
            carry_d = 1'b0;
          end
          OP_NOR: begin
            acc_d   = ~(acc_q | opd_q);
            carry_d = 1'b0;
          end
`ifdef ALU_SEQ_DIV_EN
          // Only a zero divisor reaches EXEC with a DIV opcode
          OP_DIV: begin
            carry_d = 1'b0;
            err_d   = 1'b1;
          end
`endif
          default: begin
            err_d = 1'b1;
          end
        endcase
      end

      MUL: begin
        prod_d   = prod_next;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          acc_d   = prod_next[WIDTH-1:0];
          carry_d = |prod_next[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = MUL;
        end
      end

      DIV: begin
`ifdef ALU_SEQ_DIV_EN
        quo_d = quo_next;
        rmd_d = rmd_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          acc_d   = quo_next;
          rem_d   = rmd_next;
          carry_d = 1'b0;
          err_d   = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DIV;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= 4'b0000;
      opd_q    <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
`ifdef ALU_SEQ_DIV_EN
      quo_q    <= {WIDTH{1'b0}};
      rmd_q    <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef ALU_SEQ_DIV_EN
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign acc       = acc_q;
  assign rem       = rem_q;
  assign carry     = carry_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_MULT  = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;
  logic [15:0] acc;
  logic [15:0] rem;
  logic        carry;
  logic        err;
  logic        done;

  int checks;
  int errors;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_operand(cmd_operand),
    .acc        (acc),
    .rem        (rem),
    .carry      (carry),
    .err        (err),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and return accept-to-done latency (accept cycle counts as 1)
  task automatic do_cmd(input logic [3:0] op, input logic [15:0] opd, output int lat);
    int w;
    lat = -1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    cmd_opcode  = op;
    cmd_operand = opd;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout op=%h: no done within 40 cycles, required a done pulse", op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({acc, rem, carry, err, done, cmd_ready} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state acc=%h rem=%h carry=%b err=%b done=%b ready=%b required all zero",
               acc, rem, carry, err, done, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b required=1", cmd_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    do_cmd(OP_RESET, 16'h1234, lat);
    for (int i = 1; i <= 3; i++) begin
      do_cmd(OP_ADD, 16'h0001, lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL add_latency iter=%0d got=%0d required=2", i, lat);
      end
    end
    checks++;
    if (acc !== 16'h0003 || carry !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_x3 acc=%h carry=%b err=%b required acc=0003 carry=0 err=0", acc, carry, err);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_with_done got=%b required=1", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse got=%b required=0", done);
    end
  endtask

  task automatic test_add_sub_carry();
    int lat;
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_SUB, 16'h0001, lat);
    checks++;
    if (acc !== 16'hFFFF || carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow acc=%h carry=%b required acc=ffff carry=1", acc, carry);
    end
    do_cmd(OP_ADD, 16'h0002, lat);
    checks++;
    if (acc !== 16'h0001 || carry !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap acc=%h carry=%b err=%b required acc=0001 carry=1 err=0", acc, carry, err);
    end
    do_cmd(OP_SUB, 16'h0005, lat);
    checks++;
    if (acc !== 16'hFFFC || carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_wrap acc=%h carry=%b required acc=fffc carry=1", acc, carry);
    end
    do_cmd(4'b1010, 16'h0003, lat);
    checks++;
    if (acc !== 16'hFFFC || carry !== 1'b1 || err !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL illegal_1010 acc=%h carry=%b err=%b lat=%0d required acc=fffc carry=1 err=1 lat=2",
               acc, carry, err, lat);
    end
    do_cmd(OP_SUB, 16'h0002, lat);
    checks++;
    if (acc !== 16'hFFFA || carry !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL sub_no_borrow acc=%h carry=%b err=%b required acc=fffa carry=0 err=0", acc, carry, err);
    end
  endtask

  task automatic test_mult();
    int lat;
    int bad_ready;
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_ADD, 16'h0300, lat);
    cmd_opcode  = OP_MULT;
    cmd_operand = 16'h0100;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_opcode = OP_NOOP;
    bad_ready  = 0;
    lat        = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n + 1;
        break;
      end else if (cmd_ready !== 1'b0) begin
        bad_ready++;
      end else if (acc !== 16'h0300) begin
        bad_ready++;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL mult_latency got=%0d required=17", lat);
    end
    checks++;
    if (bad_ready !== 0) begin
      errors++;
      $display("FAIL mult_busy_ready_or_acc bad_cycles=%0d required=0", bad_ready);
    end
    checks++;
    if (acc !== 16'h0000 || carry !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL mult_overflow acc=%h carry=%b err=%b required acc=0000 carry=1 err=0", acc, carry, err);
    end
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_ADD, 16'h0003, lat);
    do_cmd(OP_MULT, 16'h0005, lat);
    checks++;
    if (acc !== 16'h000F || carry !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL mult_small acc=%h carry=%b lat=%0d required acc=000f carry=0 lat=17", acc, carry, lat);
    end
  endtask

  task automatic test_div();
    int lat;
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_ADD, 16'h0064, lat);
    do_cmd(OP_DIV, 16'h0007, lat);
`ifdef ALU_SEQ_DIV_EN
    checks++;
    if (acc !== 16'h000E || rem !== 16'h0002 || carry !== 1'b0 || err !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL div_100_7 acc=%h rem=%h carry=%b err=%b lat=%0d required acc=000e rem=0002 carry=0 err=0 lat=17",
               acc, rem, carry, err, lat);
    end
    do_cmd(OP_DIV, 16'h0000, lat);
    checks++;
    if (acc !== 16'h000E || rem !== 16'h0002 || carry !== 1'b0 || err !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL div_by_zero acc=%h rem=%h carry=%b err=%b lat=%0d required acc=000e rem=0002 carry=0 err=1 lat=2",
               acc, rem, carry, err, lat);
    end
`else
    checks++;
    if (acc !== 16'h0064 || rem !== 16'h0000 || err !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL div_disabled acc=%h rem=%h err=%b lat=%0d required acc=0064 rem=0000 err=1 lat=2",
               acc, rem, err, lat);
    end
`endif
  endtask

  task automatic test_logic();
    int lat;
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_ADD, 16'h00F0, lat);
    do_cmd(OP_AND, 16'h003C, lat);
    checks++;
    if (acc !== 16'h0030 || carry !== 1'b0) begin
      errors++;
      $display("FAIL and acc=%h carry=%b required acc=0030 carry=0", acc, carry);
    end
    do_cmd(OP_NOR, 16'h000F, lat);
    checks++;
    if (acc !== 16'hFFC0) begin
      errors++;
      $display("FAIL nor acc=%h required=ffc0", acc);
    end
    do_cmd(OP_NOT, 16'hAAAA, lat);
    checks++;
    if (acc !== 16'h003F) begin
      errors++;
      $display("FAIL not acc=%h required=003f", acc);
    end
    do_cmd(4'b1111, 16'h1234, lat);
    checks++;
    if (acc !== 16'h003F || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_1111 acc=%h err=%b required acc=003f err=1", acc, err);
    end
    do_cmd(OP_NOOP, 16'h5555, lat);
    checks++;
    if (acc !== 16'h003F || err !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL noop acc=%h err=%b lat=%0d required acc=003f err=0 lat=2", acc, err, lat);
    end
    do_cmd(OP_OR, 16'h0100, lat);
    checks++;
    if (acc !== 16'h013F || carry !== 1'b0) begin
      errors++;
      $display("FAIL or acc=%h carry=%b required acc=013f carry=0", acc, carry);
    end
  endtask

  task automatic test_reset_mid_mult();
    int lat;
    int done_seen;
    do_cmd(OP_RESET, 16'h0000, lat);
    do_cmd(OP_ADD, 16'h0002, lat);
    cmd_opcode  = OP_MULT;
    cmd_operand = 16'h0003;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (acc !== 16'h0000 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mult acc=%h done=%b ready=%b required acc=0000 done=0 ready=0",
               acc, done, cmd_ready);
    end
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort got=%b required=1", cmd_ready);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL aborted_done pulses=%0d required=0", done_seen);
    end
    do_cmd(OP_ADD, 16'h0005, lat);
    checks++;
    if (acc !== 16'h0005 || carry !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL add_after_abort acc=%h carry=%b lat=%0d required acc=0005 carry=0 lat=2", acc, carry, lat);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'b0000;
    cmd_operand = 16'h0000;
    test_reset();
    test_add();
    test_add_sub_carry();
    test_mult();
    test_div();
    test_logic();
    test_reset_mid_mult();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
